// File: rtl/mux1hot_pipe.sv
// One-hot select mux with a one-entry registered output stage, select legality
// checking and a saturating illegal-select counter. Optional: MUX1HOT_PIPE_PRIORITY_EN.
module mux1hot_pipe #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int CNTW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_err,
  output logic [CNTW-1:0]    err_cnt
);

  localparam logic [N-1:0]    SEL_ONE = N'(1);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // Handshake: a transfer happens on a side when its valid and ready are both
  // high at the rising edge; valid never drops and data never changes until
  // the transfer completes. in_ready opens when the output slot is empty or
  // is being drained in the same cycle.
  logic             accept;
  logic             sel_legal;
  logic [WIDTH-1:0] mux_data;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
  assign sel_legal = (in_sel != '0) && ((in_sel & (in_sel - SEL_ONE)) == '0);

`ifdef MUX1HOT_PIPE_PRIORITY_EN
  // Lowest-index set bit wins; a zero select yields zero data.
  always_comb begin : prio_mux
    logic found;
    found    = 1'b0;
    mux_data = '0;
    for (int i = 0; i < N; i++) begin
      if (in_sel[i] && !found) begin
        mux_data = in_data[i*WIDTH +: WIDTH];
        found    = 1'b1;
      end
    end
  end
`else
  // AND-OR over the select gated by legality, so any illegal select gives zero.
  always_comb begin : andor_mux
    mux_data = '0;
    for (int i = 0; i < N; i++) begin
      if (in_sel[i] && sel_legal) begin
        mux_data = mux_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_err   <= !sel_legal;
        if (!sel_legal && (err_cnt != CNT_MAX)) begin
          err_cnt <= err_cnt + CNT_ONE;
        end
      end else if (out_ready) begin
        // Drain with nothing new: data and error flag keep their last values.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux1hot_pipe.sv
// Bench for mux1hot_pipe: transaction-queue model checked every cycle, plus
// directed literal checks; a second instance with CNTW=2 covers saturation.
module tb_mux1hot_pipe;

  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_sel;
  logic               in_valid;
  logic               in_ready, in_ready_s;
  logic [WIDTH-1:0]   out_data, out_data_s;
  logic               out_valid, out_valid_s;
  logic               out_ready;
  logic               out_err, out_err_s;
  logic [7:0]         err_cnt;
  logic [1:0]         err_cnt_s;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mux1hot_pipe #(.WIDTH(WIDTH), .N(N), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err),
    .err_cnt(err_cnt)
  );

  mux1hot_pipe #(.WIDTH(WIDTH), .N(N), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready_s), .out_data(out_data_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_err(out_err_s),
    .err_cnt(err_cnt_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [WIDTH-1:0] model_mux(input logic [N*WIDTH-1:0] d, input logic [N-1:0] s);
    if ($countones(s) == 1) begin
      for (int i = 0; i < N; i++) if (s[i]) return d[i*WIDTH +: WIDTH];
    end
`ifdef MUX1HOT_PIPE_PRIORITY_EN
    for (int i = 0; i < N; i++) if (s[i]) return d[i*WIDTH +: WIDTH];
`endif
    return '0;
  endfunction

  // exp_q holds {err, data} of the transaction sitting in the output slot.
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] last_out = '0;
  int             m_cnt    = 0;
  bit             model_on = 0;

  always @(posedge clk) begin
    bit acc;
    bit bad;
    if (rst) begin
      exp_q.delete();
      last_out = '0;
      m_cnt    = 0;
      model_on = 1;
    end else if (model_on) begin
      acc = in_valid && (exp_q.size() == 0 || out_ready);
      if (exp_q.size() > 0 && out_ready) last_out = exp_q.pop_front();
      if (acc) begin
        bad = ($countones(in_sel) != 1);
        exp_q.push_back({bad, model_mux(in_data, in_sel)});
        if (bad) m_cnt++;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [WIDTH:0] cur;
    if (model_on) begin
      cur = (exp_q.size() > 0) ? exp_q[0] : last_out;
      check("sb_out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      check("sb_out_data",  32'(out_data),  32'(cur[WIDTH-1:0]));
      check("sb_out_err",   32'(out_err),   32'(cur[WIDTH]));
      check("sb_in_ready",  32'(in_ready),  32'(exp_q.size() == 0 || out_ready));
      check("sb_err_cnt",   32'(err_cnt),   (m_cnt > 255) ? 32'd255 : 32'(m_cnt));
      check("sb_sat_cnt",   32'(err_cnt_s), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
      check("sb_sat_data",  32'(out_data_s), 32'(cur[WIDTH-1:0]));
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] s, input logic r);
    in_valid  = v;
    in_sel    = s;
    out_ready = r;
  endtask

  logic [7:0] stream_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [1:0] sat_exp    [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [N-1:0] mix_sel  [12] = '{4'b0001, 4'b1000, 4'b0000, 4'b0010, 4'b1100, 4'b0100,
                                  4'b1111, 4'b1000, 4'b0001, 4'b1010, 4'b0010, 4'b0100};
  logic         mix_rdy  [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    rst = 1'b1;
    drive(1'b1, 4'b0001, 1'b1);

    // 1: reset with in_valid high
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    tick();
    check("first_accept_data",  32'(out_data),  32'h11);
    check("first_accept_valid", 32'(out_valid), 32'd1);

    // 2: streaming
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, N'(1) << i, 1'b1);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("stream_data", 32'(out_data), 32'(stream_exp[i]));
      check("stream_err",  32'(out_err),  32'd0);
    end

    // 3: back-pressure
    drive(1'b1, 4'b0100, 1'b1);
    tick();
    check("bp_load", 32'(out_data), 32'h33);
    drive(1'b1, 4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_stall_data",  32'(out_data),  32'h33);
      check("bp_stall_valid", 32'(out_valid), 32'd1);
      check("bp_stall_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_data", 32'(out_data), 32'h11);

    // 4: illegal selects
    drive(1'b1, 4'b0110, 1'b1);
    tick();
    check("ill_err", 32'(out_err), 32'd1);
    check("ill_cnt", 32'(err_cnt), 32'd1);
`ifdef MUX1HOT_PIPE_PRIORITY_EN
    check("ill_data", 32'(out_data), 32'h22);
`else
    check("ill_data", 32'(out_data), 32'h00);
`endif
    drive(1'b1, 4'b0000, 1'b1);
    tick();
    check("zero_data", 32'(out_data), 32'h00);
    check("zero_cnt",  32'(err_cnt),  32'd2);
    drive(1'b1, 4'b0001, 1'b1);
    tick();
    check("legal_after_err", 32'(out_err), 32'd0);
    drive(1'b0, 4'b0000, 1'b1);
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold",  32'(out_data),  32'h11);
    check("noacc_cnt",   32'(err_cnt),   32'd2);

    // 5: saturation on the CNTW=2 instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 4'b0011, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sat_cnt",   32'(err_cnt_s), 32'(sat_exp[i]));
      check("wide_cnt",  32'(err_cnt),   32'(i + 1));
    end

    // 6: reset mid-stall
    drive(1'b1, 4'b1001, 1'b1);
    tick();
    drive(1'b0, 4'b0000, 1'b0);
    tick();
    check("stall_pre_valid", 32'(out_valid), 32'd1);
    check("stall_pre_err",   32'(out_err),   32'd1);
    rst = 1'b1;
    tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_err",   32'(out_err),   32'd0);
    check("midrst_cnt",   32'(err_cnt),   32'd0);
    check("midrst_data",  32'(out_data),  32'd0);
    rst = 1'b0;

    // mixed traffic, checked by the scoreboard
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, mix_sel[i], mix_rdy[i]);
      tick();
    end
    drive(1'b0, 4'b0000, 1'b1);
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
